// File: rtl/pipe_risc16_core.sv
// Five-stage in-order RISC core (IF/ID/EX/MEM/WB) with unified word-addressed memory.
// Operands are bypassed into ID from MEM and WB; branches resolve in EX and squash two slots.
module pipe_risc16_core #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic clk1,
  input  logic rst_n,
  output logic halted
);
  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  logic [XLEN-1:0] Reg [0:NREGS-1];
  logic [XLEN-1:0] Mem [0:MEM_DEPTH-1];
  logic [XLEN-1:0] PC;
  logic            HALTED;
  logic            TAKEN_BRANCH;

  // IF/ID
  logic            ifid_v;
  logic [XLEN-1:0] ifid_ir, ifid_pc;
  // ID/EX
  logic            idex_v;
  logic [5:0]      idex_op;
  logic [4:0]      idex_rt, idex_rd;
  logic [XLEN-1:0] idex_pc, idex_a, idex_b, idex_imm;
  // EX/MEM
  logic            exmem_v, exmem_we;
  logic [5:0]      exmem_op;
  logic [4:0]      exmem_dst;
  logic [XLEN-1:0] exmem_alu, exmem_b;
  // MEM/WB
  logic            memwb_v, memwb_we;
  logic [5:0]      memwb_op;
  logic [4:0]      memwb_dst;
  logic [XLEN-1:0] memwb_res;

  logic [XLEN-1:0] if_ir, mem_res, id_a, id_b, ex_alu, br_tgt;
  logic [4:0]      id_rs, id_rt, ex_dst;
  logic            ex_we, br_take, hlt_in_flight, kill;

  assign halted = HALTED;
  assign if_ir  = Mem[PC[AW-1:0]];

  // MEM-stage result: loads read memory combinationally so ID can bypass them.
  assign mem_res = (exmem_op == OP_LW) ? Mem[exmem_alu[AW-1:0]] : exmem_alu;

  assign id_rs = ifid_ir[25:21];
  assign id_rt = ifid_ir[20:16];

  // Priority: R0, then MEM (younger), then WB write-through, then the register file.
  assign id_a = (id_rs == 5'd0) ? '0 :
                (exmem_v && exmem_we && exmem_dst == id_rs) ? mem_res :
                (memwb_v && memwb_we && memwb_dst == id_rs) ? memwb_res : Reg[id_rs];
  assign id_b = (id_rt == 5'd0) ? '0 :
                (exmem_v && exmem_we && exmem_dst == id_rt) ? mem_res :
                (memwb_v && memwb_we && memwb_dst == id_rt) ? memwb_res : Reg[id_rt];

  always_comb begin
    ex_alu = '0;
    ex_we  = 1'b0;
    ex_dst = idex_rt;
    case (idex_op)
      OP_ADD:  begin ex_alu = idex_a + idex_b; ex_we = 1'b1; ex_dst = idex_rd; end
      OP_SUB:  begin ex_alu = idex_a - idex_b; ex_we = 1'b1; ex_dst = idex_rd; end
      OP_AND:  begin ex_alu = idex_a & idex_b; ex_we = 1'b1; ex_dst = idex_rd; end
      OP_OR:   begin ex_alu = idex_a | idex_b; ex_we = 1'b1; ex_dst = idex_rd; end
      OP_SLT:  begin
        ex_alu = {{(XLEN-1){1'b0}}, ($signed(idex_a) < $signed(idex_b))};
        ex_we  = 1'b1;
        ex_dst = idex_rd;
      end
      OP_MUL:  begin ex_alu = idex_a * idex_b; ex_we = 1'b1; ex_dst = idex_rd; end
      OP_ADDI: begin ex_alu = idex_a + idex_imm; ex_we = 1'b1; end
      OP_SUBI: begin ex_alu = idex_a - idex_imm; ex_we = 1'b1; end
      OP_SLTI: begin
        ex_alu = {{(XLEN-1){1'b0}}, ($signed(idex_a) < $signed(idex_imm))};
        ex_we  = 1'b1;
      end
      OP_LW:   begin ex_alu = idex_a + idex_imm; ex_we = 1'b1; end
      OP_SW:   ex_alu = idex_a + idex_imm;
      default: ex_alu = '0;
    endcase
  end

  assign br_take = idex_v && (((idex_op == OP_BNEQZ) && (idex_a != '0)) ||
                              ((idex_op == OP_BEQZ)  && (idex_a == '0)));
  assign br_tgt  = idex_pc + XLEN'(1) + idex_imm;
  assign TAKEN_BRANCH = br_take;

  // Once HLT reaches EX it will retire, so everything younger is turned into bubbles.
  assign hlt_in_flight = (idex_v && idex_op == OP_HLT) || (exmem_v && exmem_op == OP_HLT) ||
                         (memwb_v && memwb_op == OP_HLT);
  assign kill = br_take || hlt_in_flight;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      PC        <= '0;
      HALTED    <= 1'b0;
      ifid_v    <= 1'b0;
      ifid_ir   <= '0;
      ifid_pc   <= '0;
      idex_v    <= 1'b0;
      idex_op   <= '0;
      idex_rt   <= '0;
      idex_rd   <= '0;
      idex_pc   <= '0;
      idex_a    <= '0;
      idex_b    <= '0;
      idex_imm  <= '0;
      exmem_v   <= 1'b0;
      exmem_we  <= 1'b0;
      exmem_op  <= '0;
      exmem_dst <= '0;
      exmem_alu <= '0;
      exmem_b   <= '0;
      memwb_v   <= 1'b0;
      memwb_we  <= 1'b0;
      memwb_op  <= '0;
      memwb_dst <= '0;
      memwb_res <= '0;
    end else if (!HALTED) begin
      PC        <= br_take ? br_tgt : PC + XLEN'(1);
      ifid_v    <= !kill;
      ifid_ir   <= if_ir;
      ifid_pc   <= PC;
      idex_v    <= ifid_v && !kill;
      idex_op   <= ifid_ir[31:26];
      idex_rt   <= ifid_ir[20:16];
      idex_rd   <= ifid_ir[15:11];
      idex_pc   <= ifid_pc;
      idex_a    <= id_a;
      idex_b    <= id_b;
      idex_imm  <= {{(XLEN-16){ifid_ir[15]}}, ifid_ir[15:0]};
      exmem_v   <= idex_v;
      exmem_we  <= ex_we;
      exmem_op  <= idex_op;
      exmem_dst <= ex_dst;
      exmem_alu <= ex_alu;
      exmem_b   <= idex_b;
      memwb_v   <= exmem_v;
      memwb_we  <= exmem_we;
      memwb_op  <= exmem_op;
      memwb_dst <= exmem_dst;
      memwb_res <= mem_res;
      if (memwb_v && memwb_op == OP_HLT) HALTED <= 1'b1;
    end
  end

  // Architectural arrays are not reset; bubbles (valid=0) never write them.
  always @(posedge clk1) begin
    if (!HALTED) begin
      if (exmem_v && exmem_op == OP_SW) Mem[exmem_alu[AW-1:0]] <= exmem_b;
      if (memwb_v && memwb_we && memwb_dst != 5'd0) Reg[memwb_dst] <= memwb_res;
    end
  end

endmodule

// File: tb/tb_pipe_risc16_core.sv
// Directed bench for pipe_risc16_core: programs are preloaded, expected state is queued
// at load time and compared once the core halts.
module tb_pipe_risc16_core;
  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  logic halted;

  pipe_risc16_core dut (.clk1(clk1), .rst_n(rst_n), .halted(halted));

  always #5 clk1 = ~clk1;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b000010, OR_ = 6'b000011;
  localparam logic [5:0] SLT = 6'b000100, MUL = 6'b000101, LW = 6'b001000, SW = 6'b001001;
  localparam logic [5:0] ADDI = 6'b001010, SUBI = 6'b001011, BNEQZ = 6'b001101, BEQZ = 6'b001110;
  localparam logic [31:0] HLT = 32'hFC000000, NOP = 32'hF8000000;

  typedef struct {
    string       tag;
    bit          is_mem;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];
  int          nchk = 0;
  int          nerr = 0;

  function automatic logic [31:0] r_t(logic [5:0] op, int rs, int rt, int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] i_t(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk1);
  endtask

  task automatic exp_reg(input string tag, input int i, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.is_mem = 1'b0; e.idx = i; e.val = v;
    sb.push_back(e);
  endtask

  task automatic exp_mem(input string tag, input int i, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.is_mem = 1'b1; e.idx = i; e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, e.is_mem ? dut.Mem[e.idx] : dut.Reg[e.idx], e.val);
    end
  endtask

  // Hold reset, load the program and Reg[k]=k, then release on a falling edge.
  task automatic start();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 32; k++) dut.Reg[k] = 32'(k);
    for (int i = 0; i < prog.size(); i++) dut.Mem[i] = prog[i];
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_halt(input string tag, input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, halted}, 32'd1);
  endtask

  task automatic load_t1();
    prog = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
             32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
    dut.Mem[120] = 32'd85;
    dut.Mem[121] = 32'd0;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_pc", dut.PC, 32'd0);
    chk("rst_halted_flag", {31'd0, dut.HALTED}, 32'd0);
    chk("rst_halted_port", {31'd0, halted}, 32'd0);
    chk("rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);

    // 1: load / add / store
    load_t1();
    exp_mem("t1_mem121", 121, 32'd130);
    exp_mem("t1_mem120", 120, 32'd85);
    exp_reg("t1_r1", 1, 32'd120);
    exp_reg("t1_r2", 2, 32'd130);
    start();
    run_halt("t1_halt20", 20);
    drain();

    // 2: R-type ALU with a NOP between instructions
    prog = '{r_t(ADD, 1, 2, 5), NOP, r_t(SUB, 1, 2, 6), NOP, r_t(SLT, 6, 1, 7), NOP,
             r_t(MUL, 3, 4, 8), NOP, r_t(AND_, 3, 2, 9), NOP, i_t(ADDI, 0, 0, 7), NOP, HLT};
    exp_reg("t2_add", 5, 32'd3);
    exp_reg("t2_sub", 6, 32'hFFFFFFFF);
    exp_reg("t2_slt", 7, 32'd1);
    exp_reg("t2_mul", 8, 32'd12);
    exp_reg("t2_and", 9, 32'd2);
    exp_reg("t2_r0", 0, 32'd0);
    start();
    run_halt("t2_halt", 60);
    drain();

    // 3: factorial loop; SW and HLT after the taken branch must be squashed
    prog = '{i_t(ADDI, 0, 10, 200), i_t(ADDI, 0, 2, 1), r_t(OR_, 20, 20, 20),
             i_t(LW, 10, 3, 0), r_t(OR_, 20, 20, 20),
             r_t(MUL, 2, 3, 2), i_t(SUBI, 3, 3, 1), r_t(OR_, 20, 20, 20),
             i_t(BNEQZ, 3, 0, -4), i_t(SW, 10, 2, -2), HLT};
    dut.Mem[200] = 32'd7;
    dut.Mem[198] = 32'd0;
    exp_mem("t3_fact", 198, 32'd5040);
    exp_reg("t3_r2", 2, 32'd5040);
    exp_reg("t3_r3", 3, 32'd0);
    start();
    run_halt("t3_halt", 300);
    drain();

    // 4: BEQZ not taken then taken
    prog = '{i_t(BEQZ, 1, 0, 5), i_t(ADDI, 0, 11, 11), i_t(ADDI, 0, 12, 12),
             i_t(BEQZ, 0, 0, 2), i_t(ADDI, 0, 13, 13), i_t(ADDI, 0, 14, 14), HLT};
    exp_reg("t4_fall1", 11, 32'd11);
    exp_reg("t4_fall2", 12, 32'd12);
    exp_reg("t4_sq1", 13, 32'hDEAD);
    exp_reg("t4_sq2", 14, 32'hDEAD);
    start();
    dut.Reg[13] = 32'hDEAD;
    dut.Reg[14] = 32'hDEAD;
    run_halt("t4_halt", 40);
    drain();

    // 5: instructions behind HLT never write; state frozen afterwards
    prog = '{HLT, i_t(ADDI, 0, 1, 99), i_t(SW, 0, 2, 100)};
    dut.Mem[100] = 32'h55;
    exp_reg("t5_r1", 1, 32'd1);
    exp_mem("t5_mem100", 100, 32'h55);
    start();
    run_halt("t5_halt", 20);
    // HLT retires in the fifth cycle, and PC advances once per cycle up to then.
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t5_pc_frozen", dut.PC, 32'd5);
      chk("t5_halted_hold", {31'd0, halted}, 32'd1);
    end
    drain();

    // 6: reset mid-run during test 1
    load_t1();
    start();
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_pc", dut.PC, 32'd0);
    chk("t6_halted_flag", {31'd0, dut.HALTED}, 32'd0);
    chk("t6_halted_port", {31'd0, halted}, 32'd0);
    exp_mem("t6_mem121", 121, 32'd130);
    tick();
    rst_n = 1'b1;
    run_halt("t6_halt", 20);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
